div_seq_32: RTL and testbench

- Multi-cycle 32-bit integer divide controller for the CPU's DIV instruction.
- Sequences a restoring shift/subtract datapath, one quotient bit per clock.
- Adds a start/busy/done handshake, signed/unsigned selection and divide-by-zero handling.
- Results are registered for the HI (remainder) and LO (quotient) register write-back.

---
 rtl/div_seq_32.sv | 116 +++++++++++
 tb/tb_div_seq_32.sv | 142 ++++++++++++++
 2 files changed

// File: rtl/div_seq_32.sv
// rtl/div_seq_32.sv - multi-cycle restoring integer divider for DIV (quotient to LO, remainder to HI)
module div_seq_32 #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             start,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quot,
  output logic [WIDTH-1:0] rem,
  output logic             div_by_zero
);

  localparam int CW = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {IDLE, ITER, FIX, DONE} state_t;

  state_t           state_q, state_d;
  logic [WIDTH:0]   a_q, a_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic [WIDTH-1:0] m_q, m_d;
  logic [CW-1:0]    count_q, count_d;
  logic             neg_quot_q, neg_quot_d;
  logic             neg_rem_q, neg_rem_d;
  logic [WIDTH-1:0] quot_q, quot_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic             dbz_q, dbz_d;
  logic [WIDTH+1:0] diff;

  always_ff @(posedge clk) begin
    if (clr) begin
      state_q    <= IDLE;
      a_q        <= '0;
      q_q        <= '0;
      m_q        <= '0;
      count_q    <= '0;
      neg_quot_q <= 1'b0;
      neg_rem_q  <= 1'b0;
      quot_q     <= '0;
      rem_q      <= '0;
      dbz_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      a_q        <= a_d;
      q_q        <= q_d;
      m_q        <= m_d;
      count_q    <= count_d;
      neg_quot_q <= neg_quot_d;
      neg_rem_q  <= neg_rem_d;
      quot_q     <= quot_d;
      rem_q      <= rem_d;
      dbz_q      <= dbz_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    a_d        = a_q;
    q_d        = q_q;
    m_d        = m_q;
    count_d    = count_q;
    neg_quot_d = neg_quot_q;
    neg_rem_d  = neg_rem_q;
    quot_d     = quot_q;
    rem_d      = rem_q;
    dbz_d      = dbz_q;
    // Trial subtract of the shifted partial remainder; one extra top bit acts as the borrow.
    diff       = {a_q, q_q[WIDTH-1]} - {2'b00, m_q};

    case (state_q)
      IDLE: begin
        if (start) begin
          if (divisor == '0) begin
            quot_d  = '1;
            rem_d   = dividend;
            dbz_d   = 1'b1;
            state_d = DONE;
          end else begin
            neg_quot_d = is_signed & (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
            neg_rem_d  = is_signed & dividend[WIDTH-1];
            m_d        = (is_signed & divisor[WIDTH-1]) ? -divisor : divisor;
            q_d        = (is_signed & dividend[WIDTH-1]) ? -dividend : dividend;
            a_d        = '0;
            count_d    = '0;
            dbz_d      = 1'b0;
            state_d    = ITER;
          end
        end
      end
      ITER: begin
        q_d     = {q_q[WIDTH-2:0], ~diff[WIDTH+1]};
        a_d     = diff[WIDTH+1] ? {a_q[WIDTH-1:0], q_q[WIDTH-1]} : diff[WIDTH:0];
        count_d = count_q + 1'b1;
        if (count_q == CW'(WIDTH - 1)) state_d = FIX;
      end
      FIX: begin
        quot_d  = neg_quot_q ? -q_q : q_q;
        rem_d   = neg_rem_q ? -a_q[WIDTH-1:0] : a_q[WIDTH-1:0];
        state_d = DONE;
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign busy        = (state_q != IDLE);
  assign done        = (state_q == DONE);
  assign quot        = quot_q;
  assign rem         = rem_q;
  assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_div_seq_32.sv
// tb/tb_div_seq_32.sv - directed self-checking bench for div_seq_32
module tb_div_seq_32;

  logic        clk = 1'b0;
  logic        clr;
  logic        start;
  logic        is_signed;
  logic [31:0] dividend;
  logic [31:0] divisor;
  logic        busy;
  logic        done;
  logic [31:0] quot;
  logic [31:0] rem;
  logic        div_by_zero;

  int checks = 0;
  int errors = 0;

  div_seq_32 dut (
    .clk         (clk),
    .clr         (clr),
    .start       (start),
    .is_signed   (is_signed),
    .dividend    (dividend),
    .divisor     (divisor),
    .busy        (busy),
    .done        (done),
    .quot        (quot),
    .rem         (rem),
    .div_by_zero (div_by_zero)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Issue one divide and watch 40 edges: latency of done, pulse count, results.
  task automatic run_div(input string tag, input logic sgn, input logic [31:0] dd,
                         input logic [31:0] dv, input logic [31:0] exp_q,
                         input logic [31:0] exp_r, input logic exp_z, input int exp_lat,
                         input int restart_at);
    int pulses;
    int first;
    pulses = 0;
    first  = -1;
    is_signed = sgn;
    dividend  = dd;
    divisor   = dv;
    start     = 1'b1;
    tick();
    start     = 1'b0;
    dividend  = 32'hDEAD_BEEF;
    divisor   = 32'h0000_0003;
    is_signed = ~sgn;
    if (exp_lat > 0) chk({tag, "_busy0"}, {31'd0, busy}, 32'd1);
    if (done) begin pulses++; first = 0; end
    for (int e = 1; e <= 40; e++) begin
      start = (e == restart_at);
      tick();
      start = 1'b0;
      if (done) begin
        pulses++;
        if (first < 0) first = e;
      end
    end
    chk({tag, "_latency"}, first, exp_lat);
    chk({tag, "_pulses"}, pulses, 32'd1);
    chk({tag, "_quot"}, quot, exp_q);
    chk({tag, "_rem"}, rem, exp_r);
    chk({tag, "_dbz"}, {31'd0, div_by_zero}, {31'd0, exp_z});
    chk({tag, "_idle"}, {31'd0, busy}, 32'd0);
  endtask

  initial begin
    int pulses;
    clr       = 1'b1;
    start     = 1'b1;
    is_signed = 1'b0;
    dividend  = 32'd100;
    divisor   = 32'd7;
    tick();
    tick();
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_quot", quot, 32'd0);
    chk("rst_rem", rem, 32'd0);
    chk("rst_dbz", {31'd0, div_by_zero}, 32'd0);
    start = 1'b0;
    clr   = 1'b0;
    tick();

    run_div("u100_7",   1'b0, 32'd100,       32'd7,         32'd14,        32'd2,         1'b0, 33, 0);
    run_div("s_m7_2",   1'b1, 32'hFFFFFFF9,  32'h00000002,  32'hFFFFFFFD,  32'hFFFFFFFF,  1'b0, 33, 0);
    run_div("s_7_m2",   1'b1, 32'h00000007,  32'hFFFFFFFE,  32'hFFFFFFFD,  32'h00000001,  1'b0, 33, 0);
    run_div("u_m7_2",   1'b0, 32'hFFFFFFF9,  32'h00000002,  32'h7FFFFFFC,  32'h00000001,  1'b0, 33, 0);
    run_div("u_max_hi", 1'b0, 32'hFFFFFFFF,  32'h80000000,  32'h00000001,  32'h7FFFFFFF,  1'b0, 33, 0);
    run_div("s_ovf",    1'b1, 32'h80000000,  32'hFFFFFFFF,  32'h80000000,  32'h00000000,  1'b0, 33, 0);
    run_div("s_m100_7", 1'b1, 32'hFFFFFF9C,  32'h00000007,  32'hFFFFFFF2,  32'hFFFFFFFE,  1'b0, 33, 0);
    run_div("dbz",      1'b0, 32'h00001234,  32'h00000000,  32'hFFFFFFFF,  32'h00001234,  1'b1, 0,  0);
    run_div("after_dbz",1'b0, 32'hFFFFFFFF,  32'h00000010,  32'h0FFFFFFF,  32'h0000000F,  1'b0, 33, 0);
    run_div("restart",  1'b0, 32'd1000,      32'd10,        32'd100,       32'd0,         1'b0, 33, 5);

    // Abort mid-iteration: after edge 10 the counter holds 10, clr lands on edge 11.
    is_signed = 1'b0;
    dividend  = 32'd500;
    divisor   = 32'd9;
    start     = 1'b1;
    tick();
    start = 1'b0;
    for (int e = 1; e <= 10; e++) tick();
    clr = 1'b1;
    tick();
    clr = 1'b0;
    chk("clr_busy", {31'd0, busy}, 32'd0);
    chk("clr_done", {31'd0, done}, 32'd0);
    chk("clr_quot", quot, 32'd0);
    chk("clr_rem", rem, 32'd0);
    pulses = 0;
    for (int e = 0; e < 40; e++) begin
      tick();
      if (done) pulses++;
    end
    chk("clr_no_done", pulses, 32'd0);

    run_div("u9_3", 1'b0, 32'd9, 32'd3, 32'd3, 32'd0, 1'b0, 33, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
